// File: rtl/rf_pkg.sv
// Shared constants and enums for the register-file write-port scheduler.
package rf_pkg;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    typedef enum logic { INIT, RUN } state_e;
    typedef enum logic { SRC_ALU, SRC_MEM } src_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter (ALU vs load unit) with a registered last-grant pointer.
import rf_pkg::*;

module rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_alu,
    input  logic req_mem,
    output logic gnt_alu,
    output logic gnt_mem
);

    src_e last_q;
    src_e last_d;

    always_comb begin
        gnt_alu = 1'b0;
        gnt_mem = 1'b0;
        if (en) begin
            if (req_alu && req_mem) begin
                gnt_mem = (last_q == SRC_ALU);
                gnt_alu = (last_q == SRC_MEM);
            end else begin
                gnt_alu = req_alu;
                gnt_mem = req_mem;
            end
        end
    end

    // Pointer only moves on an actual grant so idle cycles keep fairness state.
    always_comb begin
        last_d = last_q;
        if (gnt_alu)
            last_d = SRC_ALU;
        else if (gnt_mem)
            last_d = SRC_MEM;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_q <= SRC_ALU;
        else
            last_q <= last_d;
    end

endmodule

// File: rtl/rf_wb_sched.sv
// Single write-port scheduler: zero-fills the register file after reset, then
// arbitrates ALU and load writebacks onto registered RegWrite/wr/wd pins.
import rf_pkg::*;

module rf_wb_sched #(
    parameter int XLEN    = rf_pkg::XLEN,
    parameter int NREG    = rf_pkg::NREG,
    parameter int AW      = rf_pkg::AW,
    parameter bit INIT_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [AW-1:0]   alu_wr,
    input  logic [XLEN-1:0] alu_wd,
    input  logic            mem_valid,
    output logic            mem_ready,
    input  logic [AW-1:0]   mem_wr,
    input  logic [XLEN-1:0] mem_wd,
    output logic            RegWrite,
    output logic [AW-1:0]   wr,
    output logic [XLEN-1:0] wd,
    input  logic [AW-1:0]   q_rr1,
    input  logic [AW-1:0]   q_rr2,
    output logic            pend_hit1,
    output logic            pend_hit2,
    output logic            init_done
);

    state_e          state_q,    state_d;
    logic [AW-1:0]   cnt_q,      cnt_d;
    logic            regwrite_q, regwrite_d;
    logic [AW-1:0]   wr_q,       wr_d;
    logic [XLEN-1:0] wd_q,       wd_d;
    logic            done_q,     done_d;
    logic            gnt_alu, gnt_mem;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .en      (state_q == RUN),
        .req_alu (alu_valid),
        .req_mem (mem_valid),
        .gnt_alu (gnt_alu),
        .gnt_mem (gnt_mem)
    );

    assign alu_ready = gnt_alu;
    assign mem_ready = gnt_mem;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        regwrite_d = 1'b0;
        wr_d       = wr_q;
        wd_d       = wd_q;
        done_d     = (state_q == RUN);
        case (state_q)
            INIT: begin
                regwrite_d = 1'b1;
                wr_d       = cnt_q;
                wd_d       = '0;
                cnt_d      = cnt_q + 1'b1;
                if (cnt_q == AW'(NREG - 1)) begin
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                // x0 requests still handshake but never assert the write enable.
                if (gnt_alu) begin
                    regwrite_d = |alu_wr;
                    wr_d       = alu_wr;
                    wd_d       = alu_wd;
                end else if (gnt_mem) begin
                    regwrite_d = |mem_wr;
                    wr_d       = mem_wr;
                    wd_d       = mem_wd;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT_EN ? INIT : RUN;
            cnt_q      <= '0;
            regwrite_q <= 1'b0;
            wr_q       <= '0;
            wd_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            regwrite_q <= regwrite_d;
            wr_q       <= wr_d;
            wd_q       <= wd_d;
            done_q     <= done_d;
        end
    end

    assign RegWrite  = regwrite_q;
    assign wr        = wr_q;
    assign wd        = wd_q;
    assign init_done = done_q;

    // done_q masks the trailing zero-fill write, which is not a real hazard.
    assign pend_hit1 = regwrite_q & done_q & (wr_q == q_rr1) & (|q_rr1);
    assign pend_hit2 = regwrite_q & done_q & (wr_q == q_rr2) & (|q_rr2);

endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Write-port scheduler for the 32x32 register file, which has one write port.
- Zero-fills every register after reset, then arbitrates the ALU and load-unit writeback streams onto the single port using valid/ready handshakes and round-robin fairness.
- Drives the register file's RegWrite/wr/wd pins from registers.
- Gives decode a pending-write hazard indication for its two read addresses.

Parameters:
XLEN, 32, data width
NREG, 32, number of architectural registers
AW, 5, register address width (log2 NREG)
INIT_EN, 1, 1 = run zero-fill sequence after reset; 0 = go straight to RUN

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  asynchronous, active-high reset
alu_valid  in  1  ALU writeback request
alu_ready  out  1  ALU request accepted this cycle
alu_wr  in  AW  ALU destination register
alu_wd  in  XLEN  ALU result
mem_valid  in  1  load writeback request
mem_ready  out  1  load request accepted this cycle
mem_wr  in  AW  load destination register
mem_wd  in  XLEN  load data
RegWrite  out  1  register-file write enable (registered)
wr  out  AW  register-file write address (registered)
wd  out  XLEN  register-file write data (registered)
q_rr1  in  AW  decode read address 1
q_rr2  in  AW  decode read address 2
pend_hit1  out  1  write to q_rr1 is in flight this cycle
pend_hit2  out  1  write to q_rr2 is in flight this cycle
init_done  out  1  high once RUN is entered

Behaviour:
- Reset (async, any time, including mid-INIT or mid-write):
  - RegWrite=0, wr=0, wd=0, init_done=0, init counter=0.
  - Round-robin pointer set to "last grant = ALU", so the load unit wins the first tie.
  - State = INIT if INIT_EN=1, else RUN.
- INIT:
  - Each cycle: RegWrite=1, wr=counter, wd=0; counter increments.
  - Lasts NREG cycles, writing registers 0..NREG-1.
  - alu_ready=mem_ready=0 throughout; requests are held off, not dropped.
  - After the write of address NREG-1 (counter wraps to 0), next state = RUN.
  - init_done rises in the first RUN cycle, i.e. NREG+1 posedges after reset release (posedge 1 enters INIT and writes reg 0).
- RUN, arbitration (combinational ready, valid-dependent):
  - Only mem_valid: mem_ready=1.
  - Only alu_valid: alu_ready=1.
  - Both valid: grant the source not granted last; the pointer updates only on an actual grant.
  - At most one ready high per cycle.
  - A source must hold valid, wr and wd stable until it sees ready; the scheduler never drops a request.
- RUN, write issue:
  - On a granted handshake at edge N, the output registers load RegWrite=1, wr=src_wr, wd=src_wd; the register file sees the write in cycle N+1.
  - Latency is one cycle; throughput is one write per cycle.
  - With no grant: RegWrite=0, wr and wd hold their last value.
- x0 rule:
  - A request with wr=0 still completes its handshake (ready=1).
  - RegWrite stays 0 for it; the zero register is never written outside INIT.
- Hazard outputs:
  - pend_hit1 = RegWrite & (wr==q_rr1) & (q_rr1!=0); pend_hit2 likewise.
  - Both are combinational from the output registers and q_rr*.
  - Both are 0 during INIT.
- Simultaneous requests to the same destination: serviced in grant order; the later write wins in the register file.
- Reset asserted while a source is waiting: the request is lost and the source must re-present it after init_done.

Decomposition:
- Shared package rf_pkg: XLEN, NREG, AW constants; state enum {INIT, RUN}; grant-source enum {SRC_ALU, SRC_MEM}.
- One natural sub-module: rr_arb2, a 2-way round-robin arbiter with a registered last-grant pointer.
- Init counter, output registers and hazard compare stay in rf_wb_sched.

Test Plan:
- Reset release with INIT_EN=1 -> RegWrite=1, wr=0..31, wd=0 on consecutive cycles, ready=0 throughout; init_done=1 at posedge 33; a model register file reads all zeros.
- RUN, alu_valid only, wr=5, wd=0x12345678 -> alu_ready=1 same cycle; next cycle RegWrite=1, wr=5, wd=0x12345678; pend_hit1=1 when q_rr1=5.
- Both valid, held 4 cycles: mem wr=3/0xA, alu wr=4/0xB -> grants alternate MEM, ALU, MEM, ALU; each source sees ready exactly twice; output sequence (3,A),(4,B),(3,A),(4,B).
- alu_valid with wr=0, wd=0xFFFF -> alu_ready=1, RegWrite stays 0; register 0 reads 0; pend_hit1=0 when q_rr1=0.
- rst asserted at INIT cycle 10 -> outputs clear immediately (asynchronously); after release the sequence restarts at wr=0, and init_done rises 33 posedges after the new release.
- INIT_EN=0 -> init_done=1 at the first posedge after reset release; a request presented in that cycle is granted immediately.
